// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline hazard controller.
//   REG_IDX_W   : register-file index width
//   mem_state_t : data-memory handshake FSM encoding (M_IDLE=0, M_WAIT=1)
//   sat_inc32   : saturating 32-bit increment used by the optional counters
package pipe_ctrl_pkg;

  localparam int unsigned REG_IDX_W = 5;

  typedef enum logic [0:0] {
    M_IDLE = 1'b0,
    M_WAIT = 1'b1
  } mem_state_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: data-memory request/acknowledge handshake.
//   dmem_req : access request, held until ack or timeout
//   dmem_ack : memory completes the access this cycle
//   master   : controller side (drives dmem_req)
//   slave    : memory side (drives dmem_ack)
interface pipe_hazard_ctrl_if;

  logic dmem_req;
  logic dmem_ack;

  modport master (output dmem_req, input dmem_ack);
  modport slave  (input dmem_req, output dmem_ack);

endinterface

// File: rtl/pipe_hazard_ctrl_dmem_wait_fsm.sv
// dmem_wait_fsm: sequences MEM-stage data accesses through the req/ack
// handshake, counts wait states and abandons an access on timeout.
//   clk, reset_n : clock, asynchronous active-low reset
//   mem_access   : MEM instruction is a load or a store
//   dmem_ack     : memory acknowledge
//   dmem_req     : memory request (0 while reset_n is low)
//   mem_stall    : pipeline must freeze this cycle
//   timeout_hit  : last permitted wait cycle reached without ack
//   mem_err      : sticky timeout flag
module dmem_wait_fsm
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_TIMEOUT = 255,
  parameter int unsigned TO_W         = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic mem_access,
  input  logic dmem_ack,
  output logic dmem_req,
  output logic mem_stall,
  output logic timeout_hit,
  output logic mem_err
);

  localparam logic              TO_EN     = (WAIT_TIMEOUT != 0);
  localparam int unsigned       TO_LAST_I = (WAIT_TIMEOUT == 0) ? 0 : WAIT_TIMEOUT - 1;
  localparam logic [TO_W-1:0]   TO_LAST   = TO_LAST_I[TO_W-1:0];

  mem_state_t       state_r;
  logic [TO_W-1:0]  cnt_r;
  logic             mem_err_r;
  logic             req_s;
  logic             hit_s;
  logic             stall_s;

  // Request, timeout and stall decode from FSM state and inputs.
  always_comb begin
    req_s   = 1'b0;
    hit_s   = 1'b0;
    stall_s = 1'b0;
    if (reset_n) begin
      req_s   = ((state_r == M_IDLE) & mem_access) | (state_r == M_WAIT);
      hit_s   = TO_EN & (state_r == M_WAIT) & (cnt_r == TO_LAST);
      stall_s = req_s & ~dmem_ack & ~hit_s;
    end else begin
      req_s   = 1'b0;
      hit_s   = 1'b0;
      stall_s = 1'b0;
    end
  end

  // Handshake FSM, wait counter and sticky timeout flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= M_IDLE;
      cnt_r     <= '0;
      mem_err_r <= 1'b0;
    end else begin
      case (state_r)
        M_IDLE: begin
          cnt_r <= '0;
          if (stall_s) state_r <= M_WAIT;
        end
        M_WAIT: begin
          cnt_r <= cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
          if (dmem_ack || hit_s) state_r <= M_IDLE;
        end
        default: begin
          state_r <= M_IDLE;
          cnt_r   <= '0;
        end
      endcase
      if (hit_s) mem_err_r <= 1'b1;
    end
  end

  assign dmem_req    = req_s;
  assign mem_stall   = stall_s;
  assign timeout_hit = hit_s;
  assign mem_err     = mem_err_r;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central stall/flush controller of the five-stage CPU.
// Detects ID/EX load-use hazards, turns a taken EX branch into IF/ID and
// ID/EX flushes, and freezes the pipeline while a MEM-stage data access
// waits for its acknowledge.
//   clk, reset_n            : clock, asynchronous active-low reset
//   dmem (master)           : dmem_req / dmem_ack handshake
//   id_rs1/2, id_uses_rs1/2 : ID source registers and their use flags
//   ex_rd, ex_mem_reg, ex_reg_wr, ex_branch_taken : EX stage status
//   mem_mem_reg, mem_dwe    : MEM stage load / store byte enables
//   *_stall, *_flush        : pipeline register controls (combinational)
//   mem_err                 : sticky memory timeout
// Optional build macro PIPE_HAZARD_CTRL_PERF_CNT_EN adds the saturating
// counters stall_cycles and flush_events.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_TIMEOUT = 255,
  parameter int unsigned TO_W         = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  pipe_hazard_ctrl_if.master   dmem,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_mem_reg,
  input  logic                 ex_reg_wr,
  input  logic                 ex_branch_taken,
  input  logic                 mem_mem_reg,
  input  logic [3:0]           mem_dwe,
  output logic                 pc_stall,
  output logic                 if_id_stall,
  output logic                 id_ex_stall,
  output logic                 ex_mem_stall,
  output logic                 if_id_flush,
  output logic                 id_ex_flush,
  output logic                 mem_wb_flush,
`ifdef PIPE_HAZARD_CTRL_PERF_CNT_EN
  output logic [31:0]          stall_cycles,
  output logic [31:0]          flush_events,
`endif
  output logic                 mem_err
);

  logic mem_access_s;
  logic mem_stall_s;
  logic timeout_hit_s;
  logic load_use_s;

  assign mem_access_s = mem_mem_reg | (|mem_dwe);

  dmem_wait_fsm #(
    .WAIT_TIMEOUT (WAIT_TIMEOUT),
    .TO_W         (TO_W)
  ) u_fsm (
    .clk         (clk),
    .reset_n     (reset_n),
    .mem_access  (mem_access_s),
    .dmem_ack    (dmem.dmem_ack),
    .dmem_req    (dmem.dmem_req),
    .mem_stall   (mem_stall_s),
    .timeout_hit (timeout_hit_s),
    .mem_err     (mem_err)
  );

  // Load-use hazard: EX load writes a non-zero register that ID reads.
  always_comb begin
    load_use_s = ex_mem_reg & ex_reg_wr & (ex_rd != {REG_IDX_W{1'b0}}) &
                 ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                  (id_uses_rs2 & (id_rs2 == ex_rd)));
  end

  // Priority: memory freeze > branch flush > load-use bubble.
  // During a freeze EX is held, so branch and load-use re-evaluate later.
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_stall  = 1'b0;
    ex_mem_stall = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    if (!reset_n) begin
      pc_stall = 1'b0;
    end else if (mem_stall_s) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_stall = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (ex_branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use_s) begin
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      id_ex_flush = 1'b1;
    end else begin
      pc_stall = 1'b0;
    end
  end

`ifdef PIPE_HAZARD_CTRL_PERF_CNT_EN
  logic [31:0] stall_cycles_r;
  logic [31:0] flush_events_r;

  // Saturating stall-cycle and flush-event counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles_r <= 32'd0;
      flush_events_r <= 32'd0;
    end else begin
      if (pc_stall) stall_cycles_r <= sat_inc32(stall_cycles_r);
      if (if_id_flush | id_ex_flush) flush_events_r <= sat_inc32(flush_events_r);
    end
  end

  assign stall_cycles = stall_cycles_r;
  assign flush_events = flush_events_r;
`endif

  // timeout_hit is consumed inside the FSM; kept visible here for debug.
  logic unused_s;
  assign unused_s = timeout_hit_s;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl (WAIT_TIMEOUT=4).
// Output vector order: {dmem_req, pc_stall, if_id_stall, id_ex_stall,
// ex_mem_stall, if_id_flush, id_ex_flush, mem_wb_flush, mem_err}.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2;
  logic       ex_mem_reg, ex_reg_wr, ex_branch_taken, mem_mem_reg;
  logic [3:0] mem_dwe;
  logic       pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
  logic       if_id_flush, id_ex_flush, mem_wb_flush, mem_err;
`ifdef PIPE_HAZARD_CTRL_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_events;
`endif

  int vectors    = 0;
  int miscompares = 0;

  pipe_hazard_ctrl_if dmem_bus ();

  pipe_hazard_ctrl #(.WAIT_TIMEOUT(4), .TO_W(8)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .dmem            (dmem_bus),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_uses_rs1     (id_uses_rs1),
    .id_uses_rs2     (id_uses_rs2),
    .ex_rd           (ex_rd),
    .ex_mem_reg      (ex_mem_reg),
    .ex_reg_wr       (ex_reg_wr),
    .ex_branch_taken (ex_branch_taken),
    .mem_mem_reg     (mem_mem_reg),
    .mem_dwe         (mem_dwe),
    .pc_stall        (pc_stall),
    .if_id_stall     (if_id_stall),
    .id_ex_stall     (id_ex_stall),
    .ex_mem_stall    (ex_mem_stall),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .mem_wb_flush    (mem_wb_flush),
`ifdef PIPE_HAZARD_CTRL_PERF_CNT_EN
    .stall_cycles    (stall_cycles),
    .flush_events    (flush_events),
`endif
    .mem_err         (mem_err)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] outs();
    return {dmem_bus.dmem_req, pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
            if_id_flush, id_ex_flush, mem_wb_flush, mem_err};
  endfunction

  task automatic chk(input string tag, input logic [8:0] expv);
    logic [8:0] obs;
    obs = outs();
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic clear_in();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_mem_reg = 1'b0; ex_reg_wr = 1'b0; ex_branch_taken = 1'b0;
    mem_mem_reg = 1'b0; mem_dwe = 4'h0; dmem_bus.dmem_ack = 1'b0;
  endtask

  localparam logic [8:0] ZERO   = 9'b0_0000_0000;
  localparam logic [8:0] LU     = 9'b0_1100_0100;
  localparam logic [8:0] BR     = 9'b0_0000_1100;
  localparam logic [8:0] MSTALL = 9'b1_1111_0010;
  localparam logic [8:0] REQ    = 9'b1_0000_0000;

  initial begin
    clear_in();
    reset_n = 1'b0;
    // Reset with hazard and store inputs active: everything must stay 0.
    @(negedge clk);
    ex_mem_reg = 1'b1; ex_reg_wr = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5;
    id_uses_rs2 = 1'b1; mem_dwe = 4'hF;
    #1 chk("reset", ZERO);

    @(negedge clk); clear_in(); reset_n = 1'b1;
    #1 chk("idle", ZERO);

    // Load-use on rs2 for one cycle, then the bubble clears it.
    @(negedge clk);
    ex_mem_reg = 1'b1; ex_reg_wr = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
    #1 chk("load_use_rs2", LU);
    @(negedge clk); ex_mem_reg = 1'b0; ex_reg_wr = 1'b0; ex_rd = 5'd0;
    #1 chk("load_use_cleared", ZERO);

    // Destination x0 never hazards.
    @(negedge clk); ex_mem_reg = 1'b1; ex_reg_wr = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0;
    #1 chk("rd_zero", ZERO);

    // rs1 match, then same match without register write.
    @(negedge clk); clear_in();
    ex_mem_reg = 1'b1; ex_reg_wr = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b1;
    #1 chk("load_use_rs1", LU);
    @(negedge clk); ex_reg_wr = 1'b0;
    #1 chk("no_reg_wr", ZERO);
    // rs1 matches but is unused.
    @(negedge clk); ex_reg_wr = 1'b1; id_uses_rs1 = 1'b0;
    #1 chk("rs1_unused", ZERO);

    // Branch overrides load-use.
    @(negedge clk); id_uses_rs1 = 1'b1; ex_branch_taken = 1'b1;
    #1 chk("branch_over_lu", BR);

    // Store with three wait states; branch/load-use ignored while frozen.
    @(negedge clk); clear_in(); mem_dwe = 4'hF;
    #1 chk("store_w0", MSTALL);
    @(negedge clk); ex_branch_taken = 1'b1;
    ex_mem_reg = 1'b1; ex_reg_wr = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_uses_rs1 = 1'b1;
    #1 chk("store_w1_masked", MSTALL);
    @(negedge clk);
    #1 chk("store_w2", MSTALL);
    @(negedge clk); dmem_bus.dmem_ack = 1'b1;
    #1 chk("store_ack", 9'b1_0000_1100);
    @(negedge clk); clear_in();
    #1 chk("store_idle", ZERO);

    // Back-to-back loads with same-cycle ack: no stall.
    @(negedge clk); mem_mem_reg = 1'b1; dmem_bus.dmem_ack = 1'b1;
    #1 chk("b2b_load0", REQ);
    @(negedge clk);
    #1 chk("b2b_load1", REQ);
    @(negedge clk); clear_in();
    #1 chk("b2b_idle", ZERO);

    // Timeout: 4 stall cycles, release, then sticky mem_err.
    @(negedge clk); mem_mem_reg = 1'b1;
    #1 chk("to_c0", MSTALL);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      #1 chk($sformatf("to_c%0d", i), MSTALL);
    end
    @(negedge clk);
    #1 chk("to_release", REQ);
    @(negedge clk); clear_in();
    #1 chk("to_err", 9'b0_0000_0001);
    @(negedge clk);
    #1 chk("to_err_sticky", 9'b0_0000_0001);

    // New access, then reset mid-access drops everything immediately.
    @(negedge clk); mem_dwe = 4'h1;
    #1 chk("err_access", 9'b1_1111_0011);
    @(negedge clk);
    #1 chk("err_wait", 9'b1_1111_0011);
    @(negedge clk); reset_n = 1'b0;
    #1 chk("reset_mid", ZERO);
    @(negedge clk); clear_in(); reset_n = 1'b1;
    #1 chk("after_reset", ZERO);

`ifdef PIPE_HAZARD_CTRL_PERF_CNT_EN
    vectors++;
    assert (stall_cycles === 32'd0 && flush_events === 32'd0) else begin
      miscompares++;
      $error("FAIL perf_reset: observed %0d/%0d expected 0/0", stall_cycles, flush_events);
    end
    @(negedge clk); mem_dwe = 4'hF;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); dmem_bus.dmem_ack = 1'b1;
    @(negedge clk); clear_in(); ex_branch_taken = 1'b1;
    @(negedge clk); clear_in();
    #1;
    vectors++;
    assert (stall_cycles === 32'd3) else begin
      miscompares++;
      $error("FAIL perf_stall: observed %0d expected 3", stall_cycles);
    end
    vectors++;
    assert (flush_events === 32'd1) else begin
      miscompares++;
      $error("FAIL perf_flush: observed %0d expected 1", flush_events);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
